// File: rtl/softplus_sweep_streamer.sv
// softplus_sweep_streamer
// Sweeps a signed WIDTH-bit operand from the most negative to the most
// positive code in increments of STEP. Each operand is driven to a
// combinational activation unit and held for SETTLE_CYCLES cycles. The unit's
// result is then captured, and the operand/result pair is streamed out over
// a valid/ready interface.
//
// Ports:
//   clock        system clock, rising edge
//   rst          asynchronous, active-low reset
//   start        one-cycle pulse, begins a sweep when idle
//   abort        synchronous abort back to idle
//   act_operand  operand driven to the activation unit
//   act_result   combinational result returned by the activation unit
//   out_valid    out_operand/out_result hold a captured pair
//   out_ready    downstream accepts the pair
//   out_operand  operand of the captured pair
//   out_result   result of the captured pair
//   busy         high while settling or presenting a pair
//   done         one-cycle pulse after the final pair is accepted
module softplus_sweep_streamer #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int STEP          = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] act_operand,
  input  logic [WIDTH-1:0] act_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_operand,
  output logic [WIDTH-1:0] out_result,
  output logic             busy,
  output logic             done
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]    CNT_INIT = CW'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_CODE = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
  // Largest operand that may still be advanced by STEP without passing
  // MAX_CODE; anything above it is the final sample.
  localparam logic [WIDTH-1:0] LAST_OK  = MAX_CODE - STEP_V;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] oop_q, oop_d;
  logic [WIDTH-1:0] ores_q, ores_d;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= MIN_CODE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      oop_q   <= '0;
      ores_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      oop_q   <= oop_d;
      ores_q  <= ores_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    oop_d   = oop_q;
    ores_d  = ores_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = MIN_CODE;
          cnt_d   = CNT_INIT;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          oop_d   = op_q;
          ores_d  = act_result;
          valid_d = 1'b1;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          // The signed compare stops the sweep before the operand can wrap
          // from the positive end back to MIN_CODE.
          if ($signed(op_q) > $signed(LAST_OK)) begin
            state_d = S_DONE;
          end else begin
            op_d    = op_q + STEP_V;
            cnt_d   = CNT_INIT;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every transition, including a same-cycle handshake.
    if (abort) begin
      state_d = S_IDLE;
      op_d    = MIN_CODE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end
  end

  assign act_operand = op_q;
  assign out_valid   = valid_q;
  assign out_operand = oop_q;
  assign out_result  = ores_q;
  assign busy        = (state_q == S_SETTLE) || (state_q == S_OUTPUT);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_softplus_sweep_streamer.sv
module tb_softplus_sweep_streamer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_a, rst_o;
  logic [3:0] rst_v, start_v, abort_v, ready_v;
  logic [3:0] valid_v, busy_v, done_v;
  logic [15:0] aop [4];
  logic [15:0] oop [4];
  logic [15:0] ores [4];
  logic [7:0]  aop_c, oop_c, ores_c;

  assign rst_v = {rst_o, rst_o, rst_o, rst_a};

  int n_assert = 0;
  int n_fail   = 0;

  // Nonlinear stand-in activation: (x >>> 8) squared, truncated to 16 bits.
  function automatic logic [15:0] nl(input logic [15:0] x);
    logic signed [15:0] s;
    s = $signed(x) >>> 8;
    return 16'(s * s);
  endfunction

  // Instance 0: full-resolution sweep, backpressure, abort, async reset.
  softplus_sweep_streamer #(.WIDTH(16), .SETTLE_CYCLES(2), .STEP(1)) u_a (
    .clock(clock), .rst(rst_v[0]), .start(start_v[0]), .abort(abort_v[0]),
    .act_operand(aop[0]), .act_result(aop[0] ^ 16'h00FF),
    .out_valid(valid_v[0]), .out_ready(ready_v[0]),
    .out_operand(oop[0]), .out_result(ores[0]),
    .busy(busy_v[0]), .done(done_v[0]));

  // Instance 1: coarse step, 16 pairs.
  softplus_sweep_streamer #(.WIDTH(16), .SETTLE_CYCLES(2), .STEP(4096)) u_b (
    .clock(clock), .rst(rst_v[1]), .start(start_v[1]), .abort(abort_v[1]),
    .act_operand(aop[1]), .act_result(aop[1] ^ 16'h00FF),
    .out_valid(valid_v[1]), .out_ready(ready_v[1]),
    .out_operand(oop[1]), .out_result(ores[1]),
    .busy(busy_v[1]), .done(done_v[1]));

  // Instance 2: narrow width, complete sweep of every code.
  softplus_sweep_streamer #(.WIDTH(8), .SETTLE_CYCLES(2), .STEP(1)) u_c (
    .clock(clock), .rst(rst_v[2]), .start(start_v[2]), .abort(abort_v[2]),
    .act_operand(aop_c), .act_result(aop_c ^ 8'h0F),
    .out_valid(valid_v[2]), .out_ready(ready_v[2]),
    .out_operand(oop_c), .out_result(ores_c),
    .busy(busy_v[2]), .done(done_v[2]));
  assign aop[2]  = {8'h00, aop_c};
  assign oop[2]  = {8'h00, oop_c};
  assign ores[2] = {8'h00, ores_c};

  // Instance 3: single-cycle settle with a nonlinear unit.
  softplus_sweep_streamer #(.WIDTH(16), .SETTLE_CYCLES(1), .STEP(256)) u_d (
    .clock(clock), .rst(rst_v[3]), .start(start_v[3]), .abort(abort_v[3]),
    .act_operand(aop[3]), .act_result(nl(aop[3])),
    .out_valid(valid_v[3]), .out_ready(ready_v[3]),
    .out_operand(oop[3]), .out_result(ores[3]),
    .busy(busy_v[3]), .done(done_v[3]));

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Model: the k-th pair of a sweep is MIN + k*STEP, computed in closed form.
  function automatic logic [15:0] exp_op(input int i, input int unsigned k);
    case (i)
      0:       return 16'h8000 + 16'(k);
      1:       return 16'h8000 + 16'(k * 4096);
      2:       return {8'h00, 8'h80 + 8'(k)};
      default: return 16'h8000 + 16'(k * 256);
    endcase
  endfunction

  function automatic logic [15:0] exp_res(input int i, input logic [15:0] op);
    case (i)
      0, 1:    return op ^ 16'h00FF;
      2:       return {8'h00, op[7:0] ^ 8'h0F};
      default: return nl(op);
    endcase
  endfunction

  function automatic int unsigned npairs(input int i);
    case (i)
      0:       return 65536;
      1:       return 16;
      default: return 256;
    endcase
  endfunction

  bit          active [4];
  bit          pend [4];
  bit          stall [4];
  int unsigned idx [4];
  int          hs_cnt [4];
  int          done_cnt [4];
  logic [15:0] prev_op [4];
  logic [15:0] prev_res [4];
  logic [15:0] last_op [4];
  logic [15:0] last_res [4];
  logic [15:0] first_ops [2];
  logic [15:0] cap_d [256];

  initial begin
    for (int i = 0; i < 4; i++) begin
      active[i] = 0; pend[i] = 0; stall[i] = 0; idx[i] = 0;
      hs_cnt[i] = 0; done_cnt[i] = 0;
      last_op[i] = '0; last_res[i] = '0;
    end
    first_ops[0] = '0;
    first_ops[1] = '0;
    for (int j = 0; j < 256; j++) cap_d[j] = 16'hDEAD;
  end

  // Single compare process: every cycle, every instance.
  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      bit old_pend;
      if (!rst_v[i]) begin
        active[i] = 0; pend[i] = 0; stall[i] = 0;
        chk($sformatf("dut%0d valid in reset", i), {15'd0, valid_v[i]}, 16'd0);
        chk($sformatf("dut%0d busy in reset", i), {15'd0, busy_v[i]}, 16'd0);
        chk($sformatf("dut%0d done in reset", i), {15'd0, done_v[i]}, 16'd0);
        continue;
      end
      chk($sformatf("dut%0d done", i), {15'd0, done_v[i]}, {15'd0, pend[i]});
      chk($sformatf("dut%0d busy", i), {15'd0, busy_v[i]}, {15'd0, active[i]});
      if (done_v[i]) done_cnt[i]++;
      if (!active[i]) begin
        chk($sformatf("dut%0d valid idle", i), {15'd0, valid_v[i]}, 16'd0);
      end else begin
        chk($sformatf("dut%0d act_operand", i), aop[i], exp_op(i, idx[i]));
        if (valid_v[i]) begin
          chk($sformatf("dut%0d out_operand", i), oop[i], exp_op(i, idx[i]));
          chk($sformatf("dut%0d out_result", i), ores[i], exp_res(i, exp_op(i, idx[i])));
          if (stall[i]) begin
            chk($sformatf("dut%0d stalled operand", i), oop[i], prev_op[i]);
            chk($sformatf("dut%0d stalled result", i), ores[i], prev_res[i]);
          end
        end
      end
      stall[i]    = active[i] && valid_v[i] && !ready_v[i] && !abort_v[i];
      prev_op[i]  = oop[i];
      prev_res[i] = ores[i];
      old_pend = pend[i];
      pend[i]  = 0;
      if (abort_v[i]) begin
        active[i] = 0;
      end else if (active[i] && valid_v[i] && ready_v[i]) begin
        if (i == 0 && hs_cnt[0] < 2) first_ops[hs_cnt[0]] = oop[0];
        if (i == 3) cap_d[oop[3][15:8]] = ores[3];
        hs_cnt[i]++;
        last_op[i]  = oop[i];
        last_res[i] = ores[i];
        if (idx[i] == npairs(i) - 1) begin
          active[i] = 0;
          pend[i]   = 1;
        end else begin
          idx[i]++;
        end
      end else if (!active[i] && !old_pend && start_v[i]) begin
        active[i] = 1;
        idx[i]    = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic run_to_done(input int i, input int budget);
    bit seen;
    seen = 0;
    ready_v[i] = 1'b1;
    start_v[i] = 1'b1;
    cyc(1);
    start_v[i] = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (done_v[i]) seen = 1;
      else cyc(1);
    end
    chk($sformatf("dut%0d done reached", i), {15'd0, seen}, 16'd1);
  endtask

  initial begin
    bit hit;
    rst_a = 1'b0; rst_o = 1'b0;
    start_v = '0; abort_v = '0; ready_v = '0;
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dut%0d reset act_operand", i), aop[i], (i == 2) ? 16'h0080 : 16'h8000);
      chk($sformatf("dut%0d reset out_operand", i), oop[i], 16'h0000);
      chk($sformatf("dut%0d reset out_result", i), ores[i], 16'h0000);
    end
    rst_a = 1'b1; rst_o = 1'b1;
    cyc(1);

    // Latency: start sampled at edge k gives valid after edge k+2.
    start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    chk("A busy after start", {15'd0, busy_v[0]}, 16'd1);
    cyc(1);
    chk("A valid at k+1", {15'd0, valid_v[0]}, 16'd0);
    cyc(1);
    chk("A valid at k+2", {15'd0, valid_v[0]}, 16'd1);
    chk("A first operand", oop[0], 16'h8000);
    chk("A first result", ores[0], 16'h80FF);

    // Random backpressure with a stray start, then abort on pair 100.
    hit = 0;
    for (int c = 0; c < 5000 && !hit; c++) begin
      if (valid_v[0] && oop[0] == 16'h8064) begin
        ready_v[0] = 1'b1; abort_v[0] = 1'b1; start_v[0] = 1'b0; hit = 1;
      end else begin
        ready_v[0] = 1'($urandom_range(0, 1));
        start_v[0] = (c == 7);
      end
      cyc(1);
    end
    abort_v[0] = 1'b0; ready_v[0] = 1'b0; start_v[0] = 1'b0;
    chk("A abort reached", {15'd0, hit}, 16'd1);
    chk("A valid after abort", {15'd0, valid_v[0]}, 16'd0);
    chk("A operand after abort", aop[0], 16'h8000);
    chk("A busy after abort", {15'd0, busy_v[0]}, 16'd0);
    chk("A pairs before abort", 16'(hs_cnt[0]), 16'd100);
    chk("A first pair operand", first_ops[0], 16'h8000);
    chk("A second pair operand", first_ops[1], 16'h8001);
    cyc(1);
    chk("A no done after abort", {15'd0, done_v[0]}, 16'd0);
    chk("A done count after abort", 16'(done_cnt[0]), 16'd0);

    // Restart, then async reset mid-settle.
    ready_v[0] = 1'b1;
    start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (valid_v[0]) hit = 1;
      else cyc(1);
    end
    chk("A restart valid", {15'd0, hit}, 16'd1);
    chk("A restart operand", oop[0], 16'h8000);
    chk("A restart result", ores[0], 16'h80FF);
    cyc(9);
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (busy_v[0] && !valid_v[0]) hit = 1;
      else cyc(1);
    end
    chk("A found settle", {15'd0, hit}, 16'd1);
    #2 rst_a = 1'b0;
    #1;
    chk("A async valid", {15'd0, valid_v[0]}, 16'd0);
    chk("A async busy", {15'd0, busy_v[0]}, 16'd0);
    chk("A async act_operand", aop[0], 16'h8000);
    chk("A async out_operand", oop[0], 16'h0000);
    chk("A async out_result", ores[0], 16'h0000);
    cyc(2);
    rst_a = 1'b1;
    ready_v[0] = 1'b0;
    cyc(3);
    chk("A idle after reset", {15'd0, busy_v[0]}, 16'd0);

    // Coarse step: 16 pairs ending at 0x7000.
    run_to_done(1, 500);
    chk("B pair count", 16'(hs_cnt[1]), 16'd16);
    chk("B last operand", last_op[1], 16'h7000);
    chk("B last result", last_res[1], 16'h70FF);
    cyc(2);
    chk("B operand held", aop[1], 16'h7000);
    chk("B done count", 16'(done_cnt[1]), 16'd1);

    // Narrow width: every code, ending at 0x7F.
    run_to_done(2, 2000);
    chk("C pair count", 16'(hs_cnt[2]), 16'd256);
    chk("C last operand", last_op[2], 16'h007F);
    chk("C last result", last_res[2], 16'h0070);
    cyc(2);
    chk("C operand held", aop[2], 16'h007F);
    chk("C done count", 16'(done_cnt[2]), 16'd1);

    // Nonlinear unit with one settle cycle.
    run_to_done(3, 1000);
    chk("D pair count", 16'(hs_cnt[3]), 16'd256);
    chk("D pair 0x8000", cap_d[8'h80], 16'h4000);
    chk("D pair 0xFF00", cap_d[8'hFF], 16'h0001);
    chk("D pair 0x0000", cap_d[8'h00], 16'h0000);
    chk("D pair 0x0100", cap_d[8'h01], 16'h0001);
    chk("D pair 0x7F00", cap_d[8'h7F], 16'h3F01);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/softplus_sweep_streamer.md
Name: softplus_sweep_streamer

Overview:
Sequential sweep engine for characterising the combinational activation units (softplus_squared and siblings) in hardware. It steps a signed WIDTH-bit operand from the most negative code to the most positive code, drives it to the unit under characterisation and waits a fixed settle time. It then captures the returned result and streams each operand/result pair out over a valid/ready interface to the logging/readout path. Operand order matches the team's characterisation dumps: 0x8000 up to 0xFFFF, then 0x0000 up to 0x7FFF.

Parameters:
WIDTH, 16, operand and result width (signed two's complement).
SETTLE_CYCLES, 2, clock cycles the operand is held before the result is captured (min 1).
STEP, 1, operand increment between samples (positive, less than 2^(WIDTH-1)).

Ports:
clock  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; begins a sweep when idle; ignored otherwise.
abort  input  1  synchronous abort; returns to IDLE on the next edge.
act_operand  output  WIDTH  operand driven to the activation unit.
act_result  input  WIDTH  combinational result from the activation unit.
out_valid  output  1  out_operand/out_result hold a captured pair.
out_ready  input  1  downstream accepts the pair.
out_operand  output  WIDTH  operand of the captured pair.
out_result  output  WIDTH  result of the captured pair.
busy  output  1  high in SETTLE or OUTPUT.
done  output  1  one-cycle pulse after the last pair is accepted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - act_operand=0x8000 (most negative, generalised to WIDTH).
  - out_valid=0, out_operand=0, out_result=0, busy=0, done=0, settle counter=0.
- States: IDLE, SETTLE, OUTPUT, DONE.
- IDLE:
  - start=1 at an edge → act_operand=most negative code, cnt=SETTLE_CYCLES-1, next state SETTLE.
- SETTLE:
  - cnt>0 → decrement cnt.
  - cnt==0 → at that edge, out_operand←act_operand, out_result←act_result, out_valid←1, next state OUTPUT.
  - Latency: start sampled at edge k gives out_valid high after edge k+SETTLE_CYCLES.
- OUTPUT:
  - out_valid and out_operand/out_result stay stable until out_valid&out_ready at an edge.
  - On that handshake, if act_operand > MAXPOS-STEP (signed compare, no wrap), go to DONE and drop out_valid.
  - Otherwise act_operand←act_operand+STEP, cnt←SETTLE_CYCLES-1, out_valid←0, next state SETTLE.
  - No pair is ever emitted twice or skipped. The operand never wraps from 0x7FFF to 0x8000.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - act_operand keeps the last swept value until the next start.
- busy=1 exactly in SETTLE and OUTPUT.
- Sample count: floor((2^WIDTH-1)/STEP)+1 pairs per sweep. With WIDTH=16 and STEP=1 this is 65536.
- The operand sequence is the signed arithmetic progression starting at the most negative code.
- abort:
  - Has priority over all transitions except reset.
  - From any state, next edge → IDLE, out_valid=0, done=0, cnt=0.
  - act_operand returns to the most negative code.
  - A handshake in the same cycle as abort is dropped; no done pulse is produced.
- start while busy, or in the DONE cycle: ignored.
- start and abort together in IDLE: abort wins, stay IDLE.
- out_ready high outside OUTPUT: no effect.
- Reset mid-sweep: immediate return to reset values; the sweep restarts only on a new start.

Test Plan:
1. Reset, start pulse, out_ready=1, SETTLE_CYCLES=2, act_result tied to act_operand XOR 0x00FF.
   - First out_valid 2 cycles after start with pair (0x8000, 0x80FF).
   - 65536 pairs ending at (0x7FFF, 0x7F00).
   - done pulses once, one cycle after the last handshake.
2. Backpressure: out_ready toggled pseudo-randomly.
   - Pair data stable while out_valid&!out_ready.
   - Operand sequence contiguous with no duplicates.
   - Second pair is (0x8001, ...).
3. STEP=4096, out_ready=1.
   - Exactly 16 pairs with operands 0x8000, 0x9000, ..., 0x7000.
   - done follows the 0x7000 handshake; no wrap to 0x8000.
4. Abort at pair 100 (operand 0x8064) while out_valid=1 and out_ready=1.
   - Pair not counted, out_valid=0 next cycle.
   - act_operand=0x8000, no done pulse.
   - New start restarts from (0x8000, ...).
5. Assert rst=0 asynchronously mid-SETTLE.
   - Outputs go to reset values without waiting for a clock edge.
   - start pulses during a sweep have no effect on the sequence.
6. Connect softplus_squared as act_result, SETTLE_CYCLES=1.
   - Captured pairs match the combinational model for operands 0x8000, 0xFF00, 0x0000, 0x0100 and 0x7FFF.
